// File: rtl/pe_pipe.sv
// Processing element: signed weighted sum of N_IN channels plus bias, arithmetic shift,
// leaky/ReLU activation and saturation, in a 3-stage pipeline that freezes on back-pressure.
module pe_pipe #(
    parameter int DW   = 8,
    parameter int N_IN = 2,
    parameter int SW   = 3,
    localparam int AW  = $clog2(N_IN + 2),
    localparam int CW  = (DW > 2 * SW + 2) ? DW : 2 * SW + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IN*DW-1:0] x_prev,
    input  logic [DW-1:0]      x_mem,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CW-1:0]      cfg_data,
    output logic [DW-1:0]      y_next,
    output logic [DW-1:0]      y_outmem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int PW   = 2 * DW;
    localparam int AccW = 2 * DW + $clog2(N_IN + 1);

    localparam logic [AW-1:0] AddrBias = AW'(N_IN);
    localparam logic [AW-1:0] AddrCtrl = AW'(N_IN + 1);

    logic stall;
    logic advance;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic signed [DW-1:0] w_q [N_IN];
    logic signed [DW-1:0] b_q;
    logic [SW-1:0]        shif_q;
    logic [SW-1:0]        slope_q;
    logic                 rd_q;
    logic                 wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
            b_q     <= '0;
            shif_q  <= '0;
            slope_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_addr == AW'(i)) begin
                    w_q[i] <= cfg_data[DW-1:0];
                end
            end
            if (cfg_addr == AddrBias) begin
                b_q <= cfg_data[DW-1:0];
            end
            if (cfg_addr == AddrCtrl) begin
                wr_q    <= cfg_data[0];
                rd_q    <= cfg_data[1];
                slope_q <= cfg_data[SW+1:2];
                shif_q  <= cfg_data[2*SW+1:SW+2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand select and products (feed S1)
    // ------------------------------------------------------------------
    logic signed [DW-1:0] op     [N_IN];
    logic signed [PW-1:0] prod_d [N_IN];

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            op[i] = x_prev[i*DW +: DW];
        end
        if (rd_q) begin
            op[0] = x_mem;
        end
    end

    // Operands widened first so the product is formed at full 2*DW precision.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            prod_d[i] = $signed({{DW{op[i][DW-1]}}, op[i]}) *
                        $signed({{DW{w_q[i][DW-1]}}, w_q[i]});
        end
    end

    // ------------------------------------------------------------------
    // S1: products plus the per-transaction controls captured at acceptance
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic signed [PW-1:0] s1_prod_q [N_IN];
    logic signed [DW-1:0] s1_b_q;
    logic [SW-1:0]        s1_shif_q;
    logic [SW-1:0]        s1_slope_q;
    logic                 s1_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                s1_prod_q[i] <= '0;
            end
            s1_b_q     <= '0;
            s1_shif_q  <= '0;
            s1_slope_q <= '0;
            s1_wr_q    <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
                s1_prod_q[i] <= prod_d[i];
            end
            s1_b_q     <= b_q;
            s1_shif_q  <= shif_q;
            s1_slope_q <= slope_q;
            s1_wr_q    <= wr_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: accumulate with bias, then arithmetic shift
    // ------------------------------------------------------------------
    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] pre_d;

    always_comb begin
        acc = {{(AccW - DW){s1_b_q[DW-1]}}, s1_b_q};
        for (int i = 0; i < N_IN; i++) begin
            acc = acc + {{(AccW - PW){s1_prod_q[i][PW-1]}}, s1_prod_q[i]};
        end
        pre_d = acc >>> s1_shif_q;
    end

    logic                   s2_valid_q;
    logic signed [AccW-1:0] s2_pre_q;
    logic [SW-1:0]          s2_slope_q;
    logic                   s2_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_pre_q   <= '0;
            s2_slope_q <= '0;
            s2_wr_q    <= 1'b0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_pre_q   <= pre_d;
            s2_slope_q <= s1_slope_q;
            s2_wr_q    <= s1_wr_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: activation, saturation and output routing
    // ------------------------------------------------------------------
    logic signed [AccW-1:0] act;
    logic [DW-1:0]          sat;

    // An all-ones slope selects ReLU; any other slope is a leaky right shift.
    always_comb begin
        if (!s2_pre_q[AccW-1]) begin
            act = s2_pre_q;
        end else if (&s2_slope_q) begin
            act = '0;
        end else begin
            act = s2_pre_q >>> s2_slope_q;
        end

        if ((&act[AccW-1:DW-1]) || !(|act[AccW-1:DW-1])) begin
            sat = act[DW-1:0];
        end else if (act[AccW-1]) begin
            sat = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            sat = {1'b0, {(DW - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_next    <= '0;
            y_outmem  <= '0;
        end else if (advance) begin
            out_valid <= s2_valid_q;
            y_next    <= (s2_valid_q && !s2_wr_q) ? sat : '0;
            y_outmem  <= (s2_valid_q && s2_wr_q) ? sat : '0;
        end
    end

    assign busy = s1_valid_q || s2_valid_q || out_valid;

endmodule

// File: tb/tb_pe_pipe.sv
// Self-checking bench for pe_pipe: directed cases, randomized streams with back-pressure
// against an integer reference model, config capture and mid-flight reset.
module tb_pe_pipe;

    localparam int DW   = 8;
    localparam int N_IN = 2;
    localparam int SW   = 3;
    localparam int AW   = $clog2(N_IN + 2);
    localparam int CW   = (DW > 2 * SW + 2) ? DW : 2 * SW + 2;
    localparam int XW   = N_IN * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] x_prev;
    logic [DW-1:0] x_mem;
    logic          in_valid;
    logic          in_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic [DW-1:0] y_next;
    logic [DW-1:0] y_outmem;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    always #5 clk = ~clk;

    pe_pipe #(
        .DW   (DW),
        .N_IN (N_IN),
        .SW   (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_prev    (x_prev),
        .x_mem     (x_mem),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .y_next    (y_next),
        .y_outmem  (y_outmem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct packed {
        logic [XW-1:0] xp;
        logic [DW-1:0] xm;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] yn;
        logic [DW-1:0] yo;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_stall;

    // Reference configuration as the bench believes it is programmed.
    int m_w [N_IN];
    int m_b, m_shif, m_slope, m_rd, m_wr;

    stim_t stim_q[$];
    res_t  exp_q[$];
    res_t  got_q[$];

    function automatic int sx(input int v);
        int r;
        r = v & ((1 << DW) - 1);
        if (r >= (1 << (DW - 1))) r -= (1 << DW);
        return r;
    endfunction

    function automatic logic [XW-1:0] pack2(input int x0, input int x1);
        logic [DW-1:0] a, b;
        a = DW'(x0);
        b = DW'(x1);
        return {b, a};
    endfunction

    function automatic int ctrl_word(input int shif, input int slope, input int rd, input int wr);
        return (shif << (SW + 2)) | (slope << 2) | (rd << 1) | wr;
    endfunction

    // Plain integer arithmetic from the activation rules.
    function automatic res_t model(input stim_t s);
        int   acc, pre, y, xi, ymax, ymin;
        res_t r;
        acc = m_b;
        for (int i = 0; i < N_IN; i++) begin
            xi = (i == 0 && m_rd != 0) ? sx(int'(s.xm)) : sx(int'(s.xp[i*DW +: DW]));
            acc += m_w[i] * xi;
        end
        pre = acc >>> m_shif;
        if (pre >= 0) y = pre;
        else if (m_slope == (1 << SW) - 1) y = 0;
        else y = pre >>> m_slope;
        ymax = (1 << (DW - 1)) - 1;
        ymin = -(1 << (DW - 1));
        if (y > ymax) y = ymax;
        if (y < ymin) y = ymin;
        r.yn = (m_wr != 0) ? '0 : DW'(y);
        r.yo = (m_wr != 0) ? DW'(y) : '0;
        return r;
    endfunction

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = CW'(data);
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic set_weights(input int w0, input int w1, input int b);
        cfg_write(0, w0);
        cfg_write(1, w1);
        cfg_write(N_IN, b);
        m_w[0] = sx(w0);
        m_w[1] = sx(w1);
        m_b    = sx(b);
    endtask

    task automatic set_ctrl(input int shif, input int slope, input int rd, input int wr);
        cfg_write(N_IN + 1, ctrl_word(shif, slope, rd, wr));
        m_shif  = shif;
        m_slope = slope;
        m_rd    = rd;
        m_wr    = wr;
    endtask

    // Single transaction into an idle pipe; returns the first result and its latency.
    task automatic send_one(input stim_t s, output res_t got, output int lat,
                            output bit idle_zero);
        x_prev    = s.xp;
        x_mem     = s.xm;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat       = -1;
        idle_zero = 1'b1;
        got       = '0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            if (out_valid === 1'b1) begin
                lat = k;
                got = {y_next, y_outmem};
            end else if (y_next !== '0 || y_outmem !== '0) begin
                idle_zero = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    // Streams stim_q through the DUT, with out_ready low for stall_len cycles from stall_at.
    task automatic drive(input int stall_at, input int stall_len, input int budget);
        int   cyc;
        bit   prev_stall;
        res_t prev;
        cyc        = 0;
        prev_stall = 1'b0;
        prev       = '0;
        n_stall    = 0;
        while (stim_q.size() != 0 || got_q.size() < exp_q.size()) begin
            if (cyc >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drive_timeout: got %0d results, required %0d", got_q.size(),
                         exp_q.size() + stim_q.size());
                break;
            end
            in_valid = (stim_q.size() != 0);
            if (in_valid) begin
                x_prev = stim_q[0].xp;
                x_mem  = stim_q[0].xm;
            end
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_bad++;
                $display("FAIL in_ready cyc %0d: got %b, required %b", cyc, in_ready,
                         !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_cmp++;
                if ({y_next, y_outmem, out_valid} !== {prev, 1'b1}) begin
                    n_bad++;
                    $display("FAIL hold cyc %0d: got %h/%h v=%b, required %h/%h v=1", cyc,
                             y_next, y_outmem, out_valid, prev.yn, prev.yo);
                end
            end
            if (out_valid !== 1'b1) begin
                n_cmp++;
                if (y_next !== '0 || y_outmem !== '0) begin
                    n_bad++;
                    $display("FAIL idle_zero cyc %0d: got %h/%h, required 00/00", cyc, y_next,
                             y_outmem);
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) n_stall++;
            prev = {y_next, y_outmem};
            if (out_valid && out_ready) got_q.push_back(prev);
            if (in_valid && in_ready) exp_q.push_back(model(stim_q.pop_front()));
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        x_prev    = '0;
        x_mem     = '0;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, busy, y_next, y_outmem} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b busy=%b y=%h/%h, required all 0", out_valid,
                     busy, y_next, y_outmem);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: got in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
        m_b = 0; m_shif = 0; m_slope = 0; m_rd = 0; m_wr = 0;
    endtask

    typedef struct {
        int w0, w1, b, shif, slope, rd, wr, x0, x1, xm, yn, yo;
    } case_t;

    task automatic test_directed();
        case_t cases [6] = '{
            '{3, -2, 5, 0, 1, 0, 0, 10, 4, 0, 27, 0},
            '{3, -2, 5, 0, 1, 0, 0, -10, 4, 0, -17, 0},
            '{3, -2, 5, 0, 7, 0, 0, -10, 4, 0, 0, 0},
            '{127, 127, 0, 0, 0, 0, 0, 127, 127, 0, 127, 0},
            '{127, 0, 0, 0, 0, 0, 0, -128, 0, 0, -128, 0},
            '{1, 0, 0, 2, 0, 1, 1, 99, 0, 20, 0, 5}
        };
        res_t  got, want;
        int    lat;
        bit    iz;
        stim_t s;
        for (int c = 0; c < 6; c++) begin
            set_weights(cases[c].w0, cases[c].w1, cases[c].b);
            set_ctrl(cases[c].shif, cases[c].slope, cases[c].rd, cases[c].wr);
            s.xp = pack2(cases[c].x0, cases[c].x1);
            s.xm = DW'(cases[c].xm);
            want.yn = DW'(cases[c].yn);
            want.yo = DW'(cases[c].yo);
            send_one(s, got, lat, iz);
            n_cmp++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL directed%0d_latency: got %0d, required 3", c, lat);
            end
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL directed%0d_result: got %h/%h, required %h/%h", c, got.yn,
                         got.yo, want.yn, want.yo);
            end
            n_cmp++;
            if (!iz) begin
                n_bad++;
                $display("FAIL directed%0d_idle_zero: got nonzero output, required 0", c);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        set_weights(3, -2, 5);
        set_ctrl(1, 2, 0, 0);
        stim_q.delete(); exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            s.xp = XW'($urandom);
            s.xm = DW'($urandom);
            stim_q.push_back(s);
        end
        drive(3, 5, 60);
        n_cmp++;
        if (n_stall != 5) begin
            n_bad++;
            $display("FAIL b2b_stall_cycles: got %0d, required 5", n_stall);
        end
        n_cmp++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results, required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_result%0d: got %h/%h, required %h/%h", i, got_q[i].yn,
                         got_q[i].yo, exp_q[i].yn, exp_q[i].yo);
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int r = 0; r < 6; r++) begin
            set_weights(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
            set_ctrl(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            stim_q.delete(); exp_q.delete(); got_q.delete();
            for (int i = 0; i < 16; i++) begin
                s.xp = XW'($urandom);
                s.xm = DW'($urandom);
                stim_q.push_back(s);
            end
            drive(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)), 200);
            n_cmp++;
            if (got_q.size() != 16) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d, required 16", r, got_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_result%0d: got %h/%h, required %h/%h", r, i,
                             got_q[i].yn, got_q[i].yo, exp_q[i].yn, exp_q[i].yo);
                end
            end
        end
    endtask

    // A control write in the same cycle as an acceptance must not affect that transaction.
    task automatic test_cfg_capture();
        res_t want [3];
        set_weights(1, 0, 0);
        set_ctrl(0, 0, 0, 0);
        got_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_prev    = pack2(40, 0);
        @(posedge clk); #1;
        x_prev    = pack2(44, 0);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(N_IN + 1);
        cfg_data  = CW'(ctrl_word(2, 0, 0, 1));
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        x_prev    = pack2(48, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid === 1'b1) got_q.push_back({y_next, y_outmem});
            @(posedge clk); #1;
        end
        m_shif = 2; m_slope = 0; m_rd = 0; m_wr = 1;
        want[0] = {8'd40, 8'd0};
        want[1] = {8'd44, 8'd0};
        want[2] = {8'd0, 8'd12};
        n_cmp++;
        if (got_q.size() != 3) begin
            n_bad++;
            $display("FAIL capture_count: got %0d, required 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want[i]) begin
                n_bad++;
                $display("FAIL capture%0d: got %h/%h, required %h/%h", i, got_q[i].yn,
                         got_q[i].yo, want[i].yn, want[i].yo);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit    pulse;
        res_t  got;
        int    lat;
        bit    iz;
        stim_t s;
        set_weights(5, 5, 5);
        set_ctrl(1, 1, 1, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_prev    = pack2(11, 22);
        x_mem     = 8'd33;
        @(posedge clk); #1;
        x_prev    = pack2(12, 23);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(N_IN + 1);
        cfg_data  = CW'(ctrl_word(3, 2, 0, 0));
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        rst       = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midflight_reset: got v=%b busy=%b rdy=%b, required 0/0/1", out_valid,
                     busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
        m_b = 0; m_shif = 0; m_slope = 0; m_rd = 0; m_wr = 0;
        pulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) pulse = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulse) begin
            n_bad++;
            $display("FAIL midflight_no_pulse: got activity after release, required none");
        end
        // Only w0 is reprogrammed; every other setting must read back as cleared.
        cfg_write(0, 1);
        m_w[0] = 1;
        s.xp = pack2(7, 9);
        s.xm = 8'd100;
        send_one(s, got, lat, iz);
        n_cmp++;
        if (lat != 3 || got !== {8'd7, 8'd0}) begin
            n_bad++;
            $display("FAIL cfg_cleared: got lat=%0d %h/%h, required lat=3 07/00", lat, got.yn,
                     got.yo);
        end
        n_cmp++;
        if (got !== model(s)) begin
            n_bad++;
            $display("FAIL cfg_cleared_model: got %h/%h, required %h/%h", got.yn, got.yo,
                     model(s).yn, model(s).yo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_cfg_capture();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pe_pipe.md
PE_PIPE -- requirements
Module: pe_pipe

Interface
REQ-001 SHALL have parameter DW, default 8: signed data/weight/bias width.
REQ-002 SHALL have parameter N_IN, default 2, range 2..16: number of inputs (channels).
REQ-003 SHALL have parameter SW, default 3: width of the shif and slope fields.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port x_prev, input, N_IN*DW: previous-PE outputs; channel i at bits [i*DW +: DW].
REQ-007 SHALL have port x_mem, input, DW: external-memory operand.
REQ-008 SHALL have port in_valid, input, 1: the input vector is valid.
REQ-009 SHALL have port in_ready, output, 1: the block accepts the input vector.
REQ-010 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-011 SHALL have port cfg_addr, input, $clog2(N_IN+2): configuration register index.
REQ-012 SHALL have port cfg_data, input, max(DW, 2*SW+2): configuration write data.
REQ-013 SHALL have port y_next, output, DW: result to the next PE.
REQ-014 SHALL have port y_outmem, output, DW: result to the output memory.
REQ-015 SHALL have port out_valid, output, 1: a result is present.
REQ-016 SHALL have port out_ready, input, 1: the downstream consumer accepts the result.
REQ-017 SHALL have port busy, output, 1: at least one pipeline stage holds a transaction.

Function
REQ-018 SHALL decode configuration addresses as follows:
- 0..N_IN-1: weight w[i].
- N_IN: bias b.
- N_IN+1: control {shif, slope, rd, wr} in cfg_data[2*SW+1:0], with wr in the LSB.
- Other addresses: write ignored.
REQ-019 SHALL make a configuration write visible from the cycle after cfg_we; a transaction accepted in the same cycle uses the old values.
REQ-020 SHALL accept a transaction on in_valid && in_ready.
REQ-021 SHALL drive in_ready = !stall, where stall = out_valid && !out_ready.
REQ-022 SHALL, at acceptance, use operand 0 = (rd ? x_mem : x_prev[0]); operands 1..N_IN-1 come from x_prev.
REQ-023 SHALL capture shif, slope and wr at acceptance and carry them with the transaction; later control writes do not affect in-flight data.
REQ-024 SHALL implement a 3-stage pipeline: S1 registers the N_IN signed products w[i]*x[i] (2*DW bits each).
REQ-025 SHALL compute in S2: acc = sum of products + sign-extended b, width 2*DW+$clog2(N_IN+1), with no overflow possible; then pre = acc >>> shif (arithmetic).
REQ-026 SHALL compute in S3:
- y = pre if pre >= 0;
- y = pre >>> slope if pre < 0;
- y = 0 if pre < 0 and slope is all-ones (ReLU);
- then saturate y to [-2^(DW-1), 2^(DW-1)-1].
REQ-027 SHALL present the S3 result as follows:
- wr=0: y_next = result, y_outmem = 0.
- wr=1: y_outmem = result, y_next = 0.
- out_valid = S3 valid.
REQ-028 SHALL assert out_valid exactly 3 cycles after acceptance when there is no stall; throughput is one transaction per cycle.
REQ-029 SHALL freeze all stages, data and valids, while stall is asserted; no transaction is dropped or duplicated.
REQ-030 SHALL hold y_next, y_outmem and out_valid stable while out_valid && !out_ready.
REQ-031 SHALL drive y_next = y_outmem = 0 while out_valid = 0.
REQ-032 SHALL assert busy while any of S1, S2 or S3 is valid.

Reset
REQ-033 SHALL, while rst=1, immediately clear:
- all stage valids;
- y_next, y_outmem, out_valid and busy to 0;
- all weights, b, shif, slope, rd and wr to 0.
REQ-034 SHALL discard in-flight transactions on a reset asserted mid-operation; no out_valid pulse follows reset release.
REQ-035 SHALL drive in_ready = 1 during and after reset.

Verification
REQ-036 SHALL cover (DW=8, N_IN=2, SW=3), cfg w0=3, w1=-2, b=5, shif=0, slope=1, rd=0, wr=0; x_prev=(10,4), out_ready=1 -> y_next=27 and y_outmem=0 three cycles later.
REQ-037 SHALL cover the same configuration with x_prev=(-10,4) -> pre=-33, y_next=-17; with slope=7 -> y_next=0.
REQ-038 SHALL cover w0=w1=127, x=(127,127), b=0 -> y_next=127 (saturated); w0=127, w1=0, x=(-128,0) -> y_next=-128 with slope=0.
REQ-039 SHALL cover rd=1, wr=1, x_mem=20, x_prev=(99,0), w0=1, w1=0, b=0, shif=2 -> y_outmem=5 and y_next=0.
REQ-040 SHALL cover 4 back-to-back transactions with out_ready low for 5 cycles mid-stream:
- in_ready=0 while out_valid && !out_ready;
- outputs are held stable;
- all 4 results are delivered in order with no loss.
REQ-041 SHALL cover rst asserted while 2 transactions are in flight and a control write is made during the flight -> after release: out_valid=0, busy=0, config=0; the in-flight transaction uses the shif/wr captured at acceptance.
